// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Runtime-programmable Mealy serial pattern detector. A qualified 1-bit stream
// is shifted into a history register. match is raised in the same cycle as the
// bit that completes the programmed pattern (1..MAX_LEN bits). Overlapping or
// non-overlapping detection is selected at run time. Matches are counted in a
// saturating counter.
//
// After reset the block is configured for pattern 1011, length 4,
// non-overlapping.
//
// Parameters
//   MAX_LEN  maximum pattern length in bits (>= 2)
//   CNT_W    width of match_count
//   LEN_W    derived width of the length field, $clog2(MAX_LEN)+1
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   din_valid    din is sampled this cycle
//   din          serial data bit
//   cfg_load     capture cfg_* and flush the history; the din of this cycle
//                is dropped
//   cfg_pattern  pattern; first-received bit at [len-1], last bit at [0]
//   cfg_len      pattern length (0 disables detection; > MAX_LEN is clamped)
//   cfg_overlap  1 = overlapping, 0 = non-overlapping detection
//   cnt_clr      synchronous clear of match_count
//   match        combinational: the current din completes the pattern
//   match_count  saturating count of matches
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  // ---------------------------------------------------------------------------
  // Reset configuration: pattern 1011, length 4 (clamped if MAX_LEN is
  // smaller), non-overlapping.
  // ---------------------------------------------------------------------------
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam int                 RST_LEN_I = (MAX_LEN < 4) ? MAX_LEN : 4;
  localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(RST_LEN_I);
  localparam logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(4'b1011);

  // Active configuration. len_q always holds the effective length because
  // the clamp is applied when the length is loaded.
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  // Accepted bits, newest at the LSB, and the number of those bits that may
  // still take part in a match (saturates at MAX_LEN).
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   avail_q;

  logic [CNT_W-1:0]   count_q;

  // Combinational helpers
  logic               accept;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic               pat_hit;
  logic               hist_ok;
  logic [LEN_W-1:0]   cfg_len_eff;
  logic [LEN_W-1:0]   avail_inc;

  // ---------------------------------------------------------------------------
  // Match evaluation
  // ---------------------------------------------------------------------------
  // A bit is accepted only when it is valid and not displaced by a config load.
  assign accept = din_valid & ~cfg_load;

  // Window of the newest MAX_LEN bits including the one arriving now. Only
  // the low len_q positions are compared against the pattern.
  assign window = {hist_q[MAX_LEN-2:0], din};

  // NOTE: every variable written in an always_comb gets a value on every
  // path (here by assigning a default first) so no latch is inferred.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign pat_hit = (((window ^ pat_q) & len_mask) == '0);

  // The current din supplies one bit, so L-1 eligible history bits are
  // needed. Compared one bit wider so avail+1 cannot wrap.
  assign hist_ok = ((LEN_W+1)'(avail_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);

  assign match = accept & (len_q != '0) & pat_hit & hist_ok;

  // ---------------------------------------------------------------------------
  // Next-state helpers
  // ---------------------------------------------------------------------------
  assign cfg_len_eff = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
  assign avail_inc   = (avail_q == MAX_LEN_L) ? avail_q : avail_q + LEN_W'(1);

  // ---------------------------------------------------------------------------
  // Configuration register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= RST_PAT;
      len_q <= RST_LEN;
      ovl_q <= 1'b0;
    end else if (cfg_load) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len_eff;
      ovl_q <= cfg_overlap;
    end
  end

  // ---------------------------------------------------------------------------
  // History and eligibility tracking
  // ---------------------------------------------------------------------------
  // cfg_load has priority: it flushes the history so a new pattern is only
  // matched against bits accepted after the load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= '0;
      avail_q <= '0;
    end else if (cfg_load) begin
      hist_q  <= '0;
      avail_q <= '0;
    end else if (din_valid) begin
      hist_q <= {hist_q[MAX_LEN-2:0], din};
      // In non-overlapping mode the bits of a found pattern are consumed.
      if (match && !ovl_q) begin
        avail_q <= '0;
      end else begin
        avail_q <= avail_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating match counter
  // ---------------------------------------------------------------------------
  // A clear coinciding with a match leaves a count of one so that match is
  // not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (cnt_clr) begin
      count_q <= match ? CNT_W'(1) : '0;
    end else if (match && !(&count_q)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed bench for seq_detector_param. Two instances share all inputs:
// u_dut with default parameters, and u_sat with CNT_W = 2 to observe counter
// saturation. Inputs change on the falling edge; match is checked just after
// that (before the rising edge that consumes it) and counts one time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 16;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               din_valid;
  logic               din;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               sat_match;
  logic [1:0]         sat_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_count (match_count)
  );

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (sat_match),
    .match_count (sat_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; match is checked before the consuming edge.
  task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                      input logic exp_m, input string tag);
    @(negedge clk);
    din_valid = v;
    din       = b;
    cfg_load  = ld;
    cnt_clr   = clr;
    #1;
    check(tag, 32'(match), 32'(exp_m));
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    cfg_load  = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic v, input logic b);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    step(v, b, 1'b1, 1'b0, 1'b0, "load_match");
  endtask

  // Sends n bits MSB-first; exp[i] is the expected match for bits[i].
  // With gaps, an invalid cycle carrying the inverted bit precedes each bit.
  task automatic send(input logic [15:0] bits, input int n, input logic [15:0] exp,
                      input logic gaps, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) step(1'b0, ~bits[i], 1'b0, 1'b0, 1'b0, {tag, "_gap"});
      step(1'b1, bits[i], 1'b0, 1'b0, exp[i], $sformatf("%s_bit%0d", tag, n - i));
    end
  endtask

  initial begin
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    reset       = 1'b1;
    din_valid   = 1'b0;
    din         = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cnt_clr     = 1'b0;

    // Reset state
    #12;
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Default configuration (1011, non-overlapping): only bit 4 matches
    send(16'b1011011, 7, 16'b0001000, 1'b0, "dflt");
    check("dflt_count", 32'(match_count), 32'd1);

    // Overlapping 1011; cfg_load leaves the count alone, cnt_clr alone clears
    load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
    check("ovl_load_count", 32'(match_count), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr_alone_match");
    check("clr_alone_count", 32'(match_count), 32'd0);
    send(16'b1011011, 7, 16'b0001001, 1'b0, "ovl");
    check("ovl_count", 32'(match_count), 32'd2);

    // 8-bit pattern A5, non-overlapping, without and with gaps
    load(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
    send(16'hA5A5, 16, 16'h0101, 1'b0, "a5");
    check("a5_count", 32'(match_count), 32'd4);
    send(16'hA5A5, 16, 16'h0101, 1'b1, "a5gap");
    check("a5gap_count", 32'(match_count), 32'd6);

    // Length 0 disables detection
    load(8'hA5, 4'd0, 1'b0, 1'b0, 1'b0);
    send(16'hA5A5, 16, 16'h0000, 1'b0, "len0");
    check("len0_count", 32'(match_count), 32'd6);

    // Reset mid-pattern discards the partial 1,0,1
    load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0);
    send(16'b101, 3, 16'b000, 1'b0, "prerst");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_count", 32'(match_count), 32'd0);
    check("async_rst_sat", 32'(sat_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(16'b1, 1, 16'b0, 1'b0, "rst_first");
    send(16'b1011, 4, 16'b0001, 1'b0, "rst_after");
    check("rst_after_count", 32'(match_count), 32'd1);

    // cfg_load coincident with the final pattern bit: bit dropped, no match
    load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0);
    send(16'b101, 3, 16'b000, 1'b0, "predrop");
    load(8'h0B, 4'd4, 1'b0, 1'b1, 1'b1);
    check("drop_count", 32'(match_count), 32'd1);
    send(16'b1011, 4, 16'b0001, 1'b0, "postdrop");
    check("postdrop_count", 32'(match_count), 32'd2);

    // cfg_len = 15 is clamped to 8: 0x25 must not match as a 7-bit pattern
    load(8'hA5, 4'd15, 1'b0, 1'b0, 1'b0);
    send(16'h25A5, 16, 16'h0001, 1'b0, "len15");
    check("len15_count", 32'(match_count), 32'd3);

    // Saturation on the 2-bit counter with a length-1 pattern
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "satclr_match");
    check("satclr_sat", 32'(sat_count), 32'd0);
    load(8'h01, 4'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, $sformatf("sat_match%0d", k + 1));
      check($sformatf("sat_count%0d", k + 1), 32'(sat_count), 32'(exp_sat[k]));
    end
    check("sat_wide_count", 32'(match_count), 32'd5);

    // cnt_clr together with a match leaves one; cnt_clr alone clears
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "clrmatch_match");
    check("clrmatch_count", 32'(match_count), 32'd1);
    check("clrmatch_sat", 32'(sat_count), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "clronly_match");
    check("clronly_count", 32'(match_count), 32'd0);
    check("clronly_sat", 32'(sat_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
